pwm_multi: RTL and testbench

//   Multi-channel PWM generator: NUM_CH outputs share one period counter.

---
 rtl/pwm_multi_if.sv | 24 ++
 rtl/pwm_multi.sv | 57 +++++
 tb/tb_pwm_multi.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pwm_multi_if.sv
// pwm_multi_if: control inputs and PWM outputs of pwm_multi.
//   master drives enable/center_mode/top/compare/polarity and observes pwm/period_start/ctr.
//   slave is the generator side.
interface pwm_multi_if #(
  parameter int CTR_LEN = 8,
  parameter int NUM_CH  = 4
);
  logic                      enable;
  logic                      center_mode;
  logic [CTR_LEN-1:0]        top;
  logic [NUM_CH*CTR_LEN-1:0] compare;
  logic [NUM_CH-1:0]         polarity;
  logic [NUM_CH-1:0]         pwm;
  logic                      period_start;
  logic [CTR_LEN-1:0]        ctr;
  modport master (
    output enable, center_mode, top, compare, polarity,
    input  pwm, period_start, ctr
  );
  modport slave (
    input  enable, center_mode, top, compare, polarity,
    output pwm, period_start, ctr
  );
endinterface

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM sharing one shadowed edge/center-aligned period counter.
//   clk  rising-edge clock
//   rst  asynchronous reset, active low
//   bus  slave side of pwm_multi_if (enable, center_mode, top, compare, polarity -> pwm, period_start, ctr)
module pwm_multi #(
  parameter int CTR_LEN = 8,
  parameter int NUM_CH  = 4
) (
  input logic        clk,
  input logic        rst,
  pwm_multi_if.slave bus
);
  localparam logic [CTR_LEN-1:0] c_one = CTR_LEN'(1);
  logic [CTR_LEN-1:0] r_ctr, r_top, w_nxt;
  logic [CTR_LEN-1:0] r_cmp [NUM_CH];
  logic               r_dir, r_mode, r_en, r_ps;
  logic               w_down, w_start, w_load;
  logic [NUM_CH-1:0]  r_pwm, w_raw;
  always_comb begin
    // Center mode turns around on reaching top; a period ends whenever the counter would return to 0.
    w_down  = r_dir || (r_ctr == r_top);
    w_nxt   = (r_top == '0) ? '0
            : r_mode ? (w_down ? r_ctr - c_one : r_ctr + c_one)
            : (r_ctr >= r_top) ? '0 : r_ctr + c_one;
    // First enabled edge holds ctr at 0 so the new period starts visibly with period_start.
    w_start = bus.enable && !r_en;
    w_load  = !bus.enable || w_start || (w_nxt == '0);
    w_raw   = '0;
    for (int i = 0; i < NUM_CH; i++) w_raw[i] = r_ctr < r_cmp[i];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ctr  <= '0;
      r_dir  <= 1'b0;
      r_top  <= '0;
      r_mode <= 1'b0;
      r_en   <= 1'b0;
      r_ps   <= 1'b0;
      r_pwm  <= '0;
      for (int i = 0; i < NUM_CH; i++) r_cmp[i] <= '0;
    end else begin
      r_en  <= bus.enable;
      r_ctr <= (bus.enable && !w_start) ? w_nxt : '0;
      r_dir <= bus.enable && !w_start && r_mode && w_down && (w_nxt != '0);
      r_ps  <= bus.enable && (w_start || (w_nxt == '0));
      r_pwm <= (bus.enable && r_en) ? (w_raw ^ bus.polarity) : bus.polarity;
      if (w_load) begin
        r_top  <= bus.top;
        r_mode <= bus.center_mode;
        for (int i = 0; i < NUM_CH; i++) r_cmp[i] <= bus.compare[i*CTR_LEN +: CTR_LEN];
      end
    end
  end
  assign bus.ctr          = r_ctr;
  assign bus.pwm          = r_pwm;
  assign bus.period_start = r_ps;
endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: period-index model of pwm_multi checked every cycle, plus hand-computed duty/sequence checks.
module tb_pwm_multi;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pwm_multi_if #(.CTR_LEN(8), .NUM_CH(4)) bus_if ();
  pwm_multi #(.CTR_LEN(8), .NUM_CH(4)) dut (.clk(clk), .rst(rst), .bus(bus_if));
  int vectors = 0;
  int miscompares = 0;
  int m_k = 0, m_top = 0, m_mode = 0, m_run = 0;
  int m_cmp [4] = '{0, 0, 0, 0};
  logic [3:0] m_pwm = '0;
  logic m_ps = 1'b0;
  int hi [4];
  int pc;
  task automatic chk(input string n, input int a, input int e);
    vectors++;
    if (a != e) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask
  function automatic int ctr_of(input int k);
    return (m_mode != 0 && k > m_top) ? 2 * m_top - k : k;
  endfunction
  function automatic int plen();
    return (m_top == 0) ? 1 : (m_mode != 0) ? 2 * m_top : m_top + 1;
  endfunction
  task automatic m_load();
    m_top  = int'(bus_if.top);
    m_mode = int'(bus_if.center_mode);
    for (int i = 0; i < 4; i++) m_cmp[i] = int'(bus_if.compare[i*8 +: 8]);
  endtask
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_k = 0; m_top = 0; m_mode = 0; m_run = 0; m_pwm = '0; m_ps = 1'b0;
      for (int i = 0; i < 4; i++) m_cmp[i] = 0;
    end else if (!bus_if.enable) begin
      m_k = 0; m_load(); m_ps = 1'b0; m_pwm = bus_if.polarity; m_run = 0;
    end else if (m_run == 0) begin
      m_k = 0; m_load(); m_ps = 1'b1; m_pwm = bus_if.polarity; m_run = 1;
    end else begin
      for (int i = 0; i < 4; i++) m_pwm[i] = (ctr_of(m_k) < m_cmp[i]) ^ bus_if.polarity[i];
      m_k++;
      m_ps = 1'b0;
      if (m_k == plen()) begin
        m_k = 0; m_load(); m_ps = 1'b1;
      end
    end
  end
  always @(negedge clk) begin
    chk("ctr", int'(bus_if.ctr), ctr_of(m_k));
    chk("pwm", int'(bus_if.pwm), int'(m_pwm));
    chk("period_start", int'(bus_if.period_start), int'(m_ps));
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic count(input int n);
    for (int i = 0; i < 4; i++) hi[i] = 0;
    pc = 0;
    repeat (n) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) hi[i] += int'(bus_if.pwm[i]);
      pc += int'(bus_if.period_start);
    end
    step(1);
  endtask
  task automatic wait_ctr(input int v);
    for (int t = 0; t < 600 && int'(bus_if.ctr) != v; t++) step(1);
    chk("wait_ctr", int'(bus_if.ctr), v);
  endtask
  task automatic wait_ps();
    for (int t = 0; t < 600 && !bus_if.period_start; t++) step(1);
    chk("wait_period_start", int'(bus_if.period_start), 1);
  endtask
  task automatic chk_hi(input string n, input int h0, input int h1, input int h2, input int h3, input int p);
    chk({n, "_hi0"}, hi[0], h0);
    chk({n, "_hi1"}, hi[1], h1);
    chk({n, "_hi2"}, hi[2], h2);
    chk({n, "_hi3"}, hi[3], h3);
    chk({n, "_starts"}, pc, p);
  endtask
  int seq [8] = '{0, 1, 2, 3, 4, 3, 2, 1};
  initial begin
    bus_if.enable = 1'b0;
    bus_if.center_mode = 1'b0;
    bus_if.top = '0;
    bus_if.compare = '0;
    bus_if.polarity = '0;
    #1 rst = 1'b0;
    step(2);
    chk("reset_ctr", int'(bus_if.ctr), 0);
    chk("reset_pwm", int'(bus_if.pwm), 0);
    chk("reset_ps", int'(bus_if.period_start), 0);
    rst = 1'b1;
    bus_if.top = 8'd9;
    bus_if.compare = {8'd0, 8'd0, 8'd5, 8'd3};
    bus_if.enable = 1'b1;
    step(1);
    chk("start_ctr", int'(bus_if.ctr), 0);
    chk("start_ps", int'(bus_if.period_start), 1);
    step(20);
    count(30);
    chk_hi("edge9", 9, 15, 0, 0, 3);
    bus_if.top = 8'd255;
    bus_if.compare = {8'd255, 8'd255, 8'd128, 8'd0};
    step(520);
    count(256);
    chk_hi("edge255", 0, 128, 255, 255, 1);
    bus_if.top = 8'd254;
    step(520);
    count(255);
    chk_hi("edge254", 0, 128, 255, 255, 1);
    bus_if.top = 8'd4;
    bus_if.center_mode = 1'b1;
    bus_if.compare = {8'd9, 8'd4, 8'd1, 8'd2};
    step(300);
    wait_ps();
    for (int i = 0; i < 8; i++) begin
      chk("center_ctr", int'(bus_if.ctr), seq[i]);
      step(1);
    end
    count(16);
    chk_hi("center4", 6, 2, 14, 16, 2);
    bus_if.center_mode = 1'b0;
    bus_if.top = 8'd9;
    bus_if.compare = {8'd0, 8'd0, 8'd0, 8'd3};
    step(30);
    wait_ctr(5);
    bus_if.compare = {8'd0, 8'd0, 8'd0, 8'd7};
    bus_if.top = 8'd19;
    step(30);
    count(40);
    chk_hi("shadow", 14, 0, 0, 0, 2);
    bus_if.polarity = 4'b0010;
    step(25);
    count(20);
    chk_hi("polarity", 7, 20, 0, 0, 1);
    bus_if.enable = 1'b0;
    step(1);
    chk("disable_ctr", int'(bus_if.ctr), 0);
    chk("disable_pwm", int'(bus_if.pwm), 2);
    chk("disable_ps", int'(bus_if.period_start), 0);
    step(3);
    bus_if.polarity = 4'b0000;
    bus_if.top = 8'd9;
    bus_if.compare = {8'd0, 8'd0, 8'd0, 8'd3};
    bus_if.enable = 1'b1;
    step(3);
    wait_ctr(6);
    #1 rst = 1'b0;
    #1;
    chk("rst_mid_ctr", int'(bus_if.ctr), 0);
    chk("rst_mid_pwm", int'(bus_if.pwm), 0);
    chk("rst_mid_ps", int'(bus_if.period_start), 0);
    step(2);
    rst = 1'b1;
    step(1);
    chk("release_ctr", int'(bus_if.ctr), 0);
    chk("release_ps", int'(bus_if.period_start), 1);
    step(30);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
